// File: rtl/decrypt_pkg.sv
// Shared constants for the RC4-style message decryptor.
// Holds the state encoding (output flags folded into the upper code bits),
// the default message length and the legal-plaintext character test.
package decrypt_pkg;

  localparam int unsigned MSG_LEN_DEF = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned STATE_W     = 9;

  // bit8 invalid, bit7 done, bit6 S-RAM wren, bit5 dc-RAM wren, bits4:0 id
  typedef enum logic [STATE_W-1:0] {
    IDLE        = 9'b0_0000_0001,
    INC_I       = 9'b0_0000_0010,
    LOAD_I      = 9'b0_0000_0011,
    READ_I      = 9'b0_0000_0100,
    SAVE_I      = 9'b0_0000_0101,
    CALC_J      = 9'b0_0000_0110,
    LOAD_J      = 9'b0_0000_0111,
    READ_J      = 9'b0_0000_1000,
    SAVE_J      = 9'b0_0000_1001,
    WRITE_I     = 9'b0_0100_1010,
    WRITE_J     = 9'b0_0100_1011,
    CALC_F_IND  = 9'b0_0000_1110,
    LOAD_F_IND  = 9'b0_0000_1111,
    READ_F_IND  = 9'b0_0001_0000,
    LOAD_ENC    = 9'b0_0001_0001,
    READ_ENC    = 9'b0_0001_0010,
    CHK_DC_DATA = 9'b0_0001_0011,
    WRITE_DC    = 9'b0_0010_0100,
    CHK_DONE    = 9'b0_0001_0101,
    INC_K       = 9'b0_0001_0110,
    DONE        = 9'b0_1000_0111,
    INVALID_D   = 9'b1_0000_1000,
    XOR_F_EN    = 9'b0_0001_1001
  } state_e;

  // Plaintext must be lower-case ASCII or a space.
  function automatic logic is_legal_char(input logic [BYTE_W-1:0] c);
    return (c == 8'd32) || ((c >= 8'd97) && (c <= 8'd122));
  endfunction

endpackage

// File: rtl/decrypt_msg.sv
// RC4 keystream generator + XOR decryptor for a MSG_LEN-byte message.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : level request; sampled in IDLE / DONE / INVALID_D
//   dm_w_q              : S-array RAM read data (1-cycle latency)
//   dm_en_r_q           : encrypted ROM read data (1-cycle latency)
//   dm_w_address/_data/_wren      : S-array RAM port
//   dm_en_r_address     : encrypted ROM address (k)
//   dm_dc_address/_data/_wren     : decrypted RAM write port
//   dm_done, dm_invalid : terminal status flags
module decrypt_msg
  import decrypt_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] dm_w_q,
  input  logic [BYTE_W-1:0] dm_en_r_q,
  output logic [BYTE_W-1:0] dm_w_address,
  output logic [BYTE_W-1:0] dm_w_data,
  output logic              dm_w_wren,
  output logic [BYTE_W-1:0] dm_en_r_address,
  output logic [BYTE_W-1:0] dm_dc_address,
  output logic [BYTE_W-1:0] dm_dc_data,
  output logic              dm_dc_wren,
  output logic              dm_done,
  output logic              dm_invalid
);

  localparam logic [BYTE_W-1:0] K_LAST = BYTE_W'(MSG_LEN - 1);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [BYTE_W-1:0] si_q, si_d, sj_q, sj_d, f_q, f_d, dc_q, dc_d;
  logic [BYTE_W-1:0] f_ind;

  // Keystream index; the swap leaves the sum of the two swapped bytes unchanged.
  assign f_ind = si_q + sj_q;

  // Status and write enables come straight from the state code bits.
  assign dm_invalid = state_q[8];
  assign dm_done    = state_q[7];
  assign dm_w_wren  = state_q[6];
  assign dm_dc_wren = state_q[5];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      dc_q    <= dc_d;
    end
  end

  // Next state, datapath updates and memory port drive.
  // Read addresses are held through LOAD/READ/SAVE so the RAM output stays
  // stable when it is captured.
  always_comb begin
    state_d         = state_q;
    i_d             = i_q;
    j_d             = j_q;
    k_d             = k_q;
    si_d            = si_q;
    sj_d            = sj_q;
    f_d             = f_q;
    dc_d            = dc_q;
    dm_w_address    = '0;
    dm_w_data       = '0;
    dm_en_r_address = '0;
    dm_dc_address   = '0;
    dm_dc_data      = '0;

    case (state_q)
      IDLE: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
        if (start) state_d = INC_I;
      end
      INC_I: begin
        i_d     = i_q + 8'd1;
        state_d = LOAD_I;
      end
      LOAD_I: begin
        dm_w_address = i_q;
        state_d      = READ_I;
      end
      READ_I: begin
        dm_w_address = i_q;
        state_d      = SAVE_I;
      end
      SAVE_I: begin
        dm_w_address = i_q;
        si_d         = dm_w_q;
        state_d      = CALC_J;
      end
      CALC_J: begin
        j_d     = j_q + si_q;
        state_d = LOAD_J;
      end
      LOAD_J: begin
        dm_w_address = j_q;
        state_d      = READ_J;
      end
      READ_J: begin
        dm_w_address = j_q;
        state_d      = SAVE_J;
      end
      SAVE_J: begin
        dm_w_address = j_q;
        sj_d         = dm_w_q;
        state_d      = WRITE_I;
      end
      WRITE_I: begin
        dm_w_address = i_q;
        dm_w_data    = sj_q;
        state_d      = WRITE_J;
      end
      WRITE_J: begin
        dm_w_address = j_q;
        dm_w_data    = si_q;
        state_d      = LOAD_F_IND;
      end
      CALC_F_IND: state_d = LOAD_F_IND;
      LOAD_F_IND: begin
        dm_w_address = f_ind;
        state_d      = READ_F_IND;
      end
      READ_F_IND: begin
        dm_w_address = f_ind;
        state_d      = LOAD_ENC;
      end
      LOAD_ENC: begin
        dm_w_address    = f_ind;
        dm_en_r_address = k_q;
        f_d             = dm_w_q;
        state_d         = READ_ENC;
      end
      READ_ENC: begin
        dm_en_r_address = k_q;
        state_d         = XOR_F_EN;
      end
      XOR_F_EN: begin
        dm_en_r_address = k_q;
        dc_d            = f_q ^ dm_en_r_q;
        state_d         = CHK_DC_DATA;
      end
      CHK_DC_DATA: begin
        dm_en_r_address = k_q;
        state_d         = is_legal_char(dc_q) ? WRITE_DC : INVALID_D;
      end
      WRITE_DC: begin
        dm_en_r_address = k_q;
        dm_dc_address   = k_q;
        dm_dc_data      = dc_q;
        state_d         = CHK_DONE;
      end
      CHK_DONE: begin
        dm_en_r_address = k_q;
        state_d         = (k_q == K_LAST) ? DONE : INC_K;
      end
      INC_K: begin
        k_d     = k_q + 8'd1;
        state_d = INC_I;
      end
      DONE, INVALID_D: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decrypt_msg.sv
// Self-checking bench for decrypt_msg: behavioural RC4 reference model,
// randomized keys/plaintext, behavioural S-array RAM and encrypted ROM.
module tb_decrypt_msg;

  localparam int unsigned MSG_LEN = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dm_w_q;
  logic [7:0] dm_en_r_q;
  logic [7:0] dm_w_address;
  logic [7:0] dm_w_data;
  logic       dm_w_wren;
  logic [7:0] dm_en_r_address;
  logic [7:0] dm_dc_address;
  logic [7:0] dm_dc_data;
  logic       dm_dc_wren;
  logic       dm_done;
  logic       dm_invalid;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  s_mem [256];
  logic [7:0]  rom   [256];
  logic [7:0]  m_s   [256];
  logic [7:0]  m_fin [256];
  logic [7:0]  ks    [256];
  logic [7:0]  pt    [256];
  logic [15:0] wr_q  [$];

  always #5 clk = ~clk;

  decrypt_msg #(.MSG_LEN(MSG_LEN)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .dm_w_q          (dm_w_q),
    .dm_en_r_q       (dm_en_r_q),
    .dm_w_address    (dm_w_address),
    .dm_w_data       (dm_w_data),
    .dm_w_wren       (dm_w_wren),
    .dm_en_r_address (dm_en_r_address),
    .dm_dc_address   (dm_dc_address),
    .dm_dc_data      (dm_dc_data),
    .dm_dc_wren      (dm_dc_wren),
    .dm_done         (dm_done),
    .dm_invalid      (dm_invalid)
  );

  // Synchronous-read memories with one cycle of read latency.
  always @(posedge clk) begin
    dm_w_q    <= s_mem[dm_w_address];
    dm_en_r_q <= rom[dm_en_r_address];
    if (dm_w_wren === 1'b1) s_mem[dm_w_address] <= dm_w_data;
  end

  // Log every decrypted-RAM write as {address, data}.
  always @(negedge clk) begin
    if (dm_dc_wren === 1'b1) wr_q.push_back({dm_dc_address, dm_dc_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] rand_legal();
    int v;
    v = $urandom_range(0, 26);
    return (v == 26) ? 8'd32 : 8'(97 + v);
  endfunction

  function automatic bit legal(input logic [7:0] c);
    return (c == " ") || (c >= "a" && c <= "z");
  endfunction

  // Reference RC4 keystream from initial S in m_s; final S into m_fin.
  task automatic gen_ks();
    logic [7:0] s [256];
    logic [7:0] t;
    int ii = 0;
    int jj = 0;
    for (int x = 0; x < 256; x++) s[x] = m_s[x];
    for (int k = 0; k < int'(MSG_LEN); k++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(s[ii])) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      ks[k] = s[(int'(s[ii]) + int'(s[jj])) % 256];
    end
    for (int x = 0; x < 256; x++) m_fin[x] = s[x];
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) begin
      m_s[x] = 8'(x);
      s_mem[x] <= 8'(x);
    end
  endtask

  task automatic load_perm();
    logic [7:0] t;
    int r;
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(0, x);
      t = m_s[x]; m_s[x] = m_s[r]; m_s[r] = t;
    end
    for (int x = 0; x < 256; x++) s_mem[x] <= m_s[x];
  endtask

  // Plaintext of legal characters, encrypted into the ROM with the model keystream.
  task automatic build_rom();
    gen_ks();
    for (int k = 0; k < 256; k++) begin
      if (k >= int'(MSG_LEN)) pt[k] = 8'h00;
      rom[k] = pt[k] ^ ks[k];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Start at the current negedge (cycle 0) and run until a terminal flag.
  task automatic run_to_end(output int cycles);
    wr_q.delete();
    start  = 1'b1;
    cycles = 0;
    while (!(dm_done === 1'b1 || dm_invalid === 1'b1) && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    logic [51:0] obs;
    do_reset();
    obs = {dm_w_address, dm_w_data, dm_w_wren, dm_en_r_address, dm_dc_address,
           dm_dc_data, dm_dc_wren, dm_done, dm_invalid, 9'd0};
    n_vec++;
    if (obs !== 52'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    repeat (3) @(negedge clk);
    obs = {dm_w_address, dm_w_data, dm_w_wren, dm_en_r_address, dm_dc_address,
           dm_dc_data, dm_dc_wren, dm_done, dm_invalid, 9'd0};
    n_vec++;
    if (obs !== 52'd0) begin
      n_err++;
      $display("FAIL idle_hold_no_start: got %h expected 0", obs);
    end
  endtask

  // Cycle-accurate first byte with S[x]=x: flags per cycle and key addresses.
  task automatic test_sequence();
    logic [3:0] exp_f;
    logic [3:0] got_f;
    do_reset();
    load_identity();
    for (int k = 0; k < int'(MSG_LEN); k++) pt[k] = rand_legal();
    pt[0] = 8'h61;
    build_rom();
    start = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) @(negedge clk);
      exp_f = {(c == 9 || c == 10), (c == 17), 1'b0, 1'b0};
      got_f = {dm_w_wren, dm_dc_wren, dm_done, dm_invalid};
      n_vec++;
      if (got_f !== exp_f) begin
        n_err++;
        $display("FAIL seq_flags cycle %0d: got %b expected %b", c, got_f, exp_f);
      end
      if (c == 2 || c == 6 || c == 22) begin
        n_vec++;
        if (dm_w_address !== ((c == 22) ? 8'd2 : 8'd1)) begin
          n_err++;
          $display("FAIL seq_rd_addr cycle %0d: got %0d", c, dm_w_address);
        end
      end
      if (c == 9 || c == 10) begin
        n_vec++;
        if ({dm_w_address, dm_w_data} !== 16'h0101) begin
          n_err++;
          $display("FAIL seq_swap cycle %0d: got %h expected 0101", c, {dm_w_address, dm_w_data});
        end
      end
      if (c == 11) begin
        n_vec++;
        if (dm_w_address !== 8'd2) begin
          n_err++;
          $display("FAIL seq_f_ind: got %0d expected 2", dm_w_address);
        end
      end
      if (c == 13) begin
        n_vec++;
        if (dm_en_r_address !== 8'd0) begin
          n_err++;
          $display("FAIL seq_enc_addr: got %0d expected 0", dm_en_r_address);
        end
      end
      if (c == 17) begin
        n_vec++;
        if ({dm_dc_address, dm_dc_data} !== 16'h0061) begin
          n_err++;
          $display("FAIL seq_dc_write: got %h expected 0061", {dm_dc_address, dm_dc_data});
        end
      end
    end
  endtask

  task automatic test_full_decrypt();
    int  cycles;
    int  bad;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      if (it == 0) load_identity(); else load_perm();
      for (int k = 0; k < int'(MSG_LEN); k++) pt[k] = rand_legal();
      build_rom();
      run_to_end(cycles);
      n_vec++;
      if (!(dm_done === 1'b1 && dm_invalid === 1'b0)) begin
        n_err++;
        $display("FAIL full_done it%0d: done=%b invalid=%b after %0d cycles", it, dm_done, dm_invalid, cycles);
      end
      n_vec++;
      if (cycles !== 608) begin
        n_err++;
        $display("FAIL full_latency it%0d: got %0d expected 608", it, cycles);
      end
      n_vec++;
      if (wr_q.size() !== int'(MSG_LEN)) begin
        n_err++;
        $display("FAIL full_wr_count it%0d: got %0d expected %0d", it, wr_q.size(), MSG_LEN);
      end
      for (int k = 0; k < wr_q.size() && k < int'(MSG_LEN); k++) begin
        n_vec++;
        if (wr_q[k] !== {8'(k), pt[k]}) begin
          n_err++;
          $display("FAIL full_byte it%0d k%0d: got %h expected %h", it, k, wr_q[k], {8'(k), pt[k]});
        end
      end
      bad = 0;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== m_fin[x]) bad++;
      n_vec++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL full_final_s it%0d: got %0d differing entries expected 0", it, bad);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (dm_done !== 1'b1) begin
        n_err++;
        $display("FAIL done_hold it%0d: got %b expected 1", it, dm_done);
      end
      start = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({dm_done, dm_w_wren, dm_dc_wren, dm_w_address} !== 11'd0) begin
        n_err++;
        $display("FAIL done_to_idle it%0d: got %h expected 0", it, {dm_done, dm_w_wren, dm_dc_wren, dm_w_address});
      end
    end
  endtask

  task automatic test_invalid();
    int         cycles;
    int         p;
    logic [7:0] bad_c;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      load_perm();
      for (int k = 0; k < int'(MSG_LEN); k++) pt[k] = rand_legal();
      p = $urandom_range(0, 9);
      if (it == 0) bad_c = 8'h41;
      else begin
        bad_c = 8'($urandom_range(0, 255));
        while (legal(bad_c)) bad_c = 8'($urandom_range(0, 255));
      end
      pt[p] = bad_c;
      build_rom();
      run_to_end(cycles);
      n_vec++;
      if (!(dm_invalid === 1'b1 && dm_done === 1'b0)) begin
        n_err++;
        $display("FAIL inv_flag it%0d: invalid=%b done=%b", it, dm_invalid, dm_done);
      end
      n_vec++;
      if (cycles !== 17 + 19 * p) begin
        n_err++;
        $display("FAIL inv_latency it%0d: got %0d expected %0d", it, cycles, 17 + 19 * p);
      end
      n_vec++;
      if (wr_q.size() !== p) begin
        n_err++;
        $display("FAIL inv_wr_count it%0d: got %0d expected %0d", it, wr_q.size(), p);
      end
      for (int k = 0; k < wr_q.size() && k < p; k++) begin
        n_vec++;
        if (wr_q[k] !== {8'(k), pt[k]}) begin
          n_err++;
          $display("FAIL inv_byte it%0d k%0d: got %h expected %h", it, k, wr_q[k], {8'(k), pt[k]});
        end
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if ({dm_invalid, dm_dc_wren} !== 2'b10) begin
        n_err++;
        $display("FAIL inv_hold it%0d: got %b expected 10", it, {dm_invalid, dm_dc_wren});
      end
      start = 1'b0;
      @(negedge clk);
      n_vec++;
      if (dm_invalid !== 1'b0) begin
        n_err++;
        $display("FAIL inv_to_idle it%0d: got %b expected 0", it, dm_invalid);
      end
    end
  endtask

  // Reset landing on a WRITE_I of the third byte, then a clean restart.
  task automatic test_reset_mid_write();
    int n;
    do_reset();
    load_identity();
    for (int k = 0; k < int'(MSG_LEN); k++) pt[k] = rand_legal();
    build_rom();
    wr_q.delete();
    start = 1'b1;
    n = 0;
    while (!(wr_q.size() >= 2 && dm_w_wren === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= 200) begin
      n_err++;
      $display("FAIL midw_reach: got timeout after %0d cycles expected WRITE_I", n);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({dm_w_wren, dm_dc_wren, dm_done, dm_invalid, dm_w_address, dm_w_data,
         dm_en_r_address, dm_dc_address, dm_dc_data} !== 44'd0) begin
      n_err++;
      $display("FAIL midw_outputs: wren=%b addr=%0d en_addr=%0d expected all 0",
               dm_w_wren, dm_w_address, dm_en_r_address);
    end
    reset = 1'b0;
    load_identity();
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 2 || c == 6) begin
        n_vec++;
        if (dm_w_address !== 8'd1) begin
          n_err++;
          $display("FAIL midw_restart_addr cycle %0d: got %0d expected 1", c, dm_w_address);
        end
      end
      if (c == 13) begin
        n_vec++;
        if (dm_en_r_address !== 8'd0) begin
          n_err++;
          $display("FAIL midw_restart_k: got %0d expected 0", dm_en_r_address);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_sequence();
    test_full_decrypt();
    test_invalid();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
